i2c_apb_sequencer: RTL
======================

Name: i2c_apb_sequencer

Overview:
- APB master that sits directly upstream of the I2C master's APB slave port.
- Turns one high-level request (7-bit slave address, direction, byte count) plus a write-byte stream into the APB register writes, status polls and receive reads that run a complete I2C transfer.
- Returns read bytes on a valid/ready stream and reports completion or timeout.

Parameters:
- PRESC_VAL, 8'd4, prescaler value written to 0x00 before every transfer
- MAX_LEN, 16, maximum bytes per request (TX/RX FIFO depth); larger req_len_i is clamped to MAX_LEN
- STATUS_ADDR, 32'h03, APB address of the status register
- RECEIVE_ADDR, 32'h05, APB address of the receive register
- TIMEOUT_CYC, 16'd50000, maximum pclk cycles spent in polling before abort

Ports:
- pclk_i  in  1  APB clock; the only clock
- preset_n_i  in  1  asynchronous active-low reset
- req_valid_i  in  1  transfer request
- req_ready_o  out  1  high only in IDLE
- req_rw_i  in  1  1 = read, 0 = write
- req_addr_i  in  7  I2C slave address
- req_len_i  in  8  byte count; 0 is treated as 1
- wr_valid_i / wr_ready_o  in/out  1  write-byte handshake
- wr_data_i  in  8  write byte
- rd_valid_o / rd_ready_i  out/in  1  read-byte handshake
- rd_data_o  out  8  read byte
- done_o  out  1  one-cycle pulse at end of transfer
- err_o  out  1  one-cycle pulse together with done_o on timeout
- psel_o, penable_o, pwrite_o  out  1  APB master controls
- paddr_o  out  32  APB address
- pwdata_o  out  32  APB write data
- prdata_i  in  32  APB read data
- pready_i  in  1  APB ready

Behaviour:
- Reset values: all outputs 0; FSM in IDLE.
- APB protocol:
  - Every register access is a SETUP cycle (psel=1, penable=0) followed by ACCESS (psel=1, penable=1).
  - ACCESS is held until pready_i=1.
  - paddr/pwrite/pwdata are stable from SETUP through completion.
  - psel and penable return to 0 for at least one cycle between accesses.
  - prdata_i is sampled in the cycle pready_i=1.
- Register map: prescaler 0x00; cmd 0x01; transmit 0x02; address_rw 0x04; status STATUS_ADDR; receive RECEIVE_ADDR.
- Bit fields:
  - cmd: [7] repeat start, [6] enable, [5] reset_n (active-low).
  - status: [7] TX FIFO empty, [6] RX FIFO full, [5] bus_free, [4] addr_done.
- FSM states and transitions:
  - IDLE: req_ready_o=1. On req_valid_i, latch rw, address and len (clamped), clear byte counter, go to RST.
  - RST: write cmd=0x00, resetting the I2C core.
  - PRESC: write 0x00 = PRESC_VAL.
  - ADDR: write 0x04 = {req_addr, rw}.
  - LOAD (write only): wr_ready_o=1 for one cycle per byte, only while no APB access is active. Each accepted byte is written to 0x02. Repeat len times, then go to START.
  - START: write cmd=0x60 (enable | reset_n).
  - POLL_BUSY: read status until bus_free=0.
  - POLL_FREE: read status until bus_free=1, and additionally TX empty=1 for writes.
  - READ (read only): read RECEIVE_ADDR, present prdata_i[7:0] on rd_data_o with rd_valid_o=1, hold until rd_ready_i. Repeat len times. No APB access is issued while rd_valid_o is high.
  - STOP: write cmd=0x20 (disable, keep reset released).
  - DONE: done_o=1 for one cycle, then return to IDLE.
- Request acceptance: a req_valid_i outside IDLE is ignored (not queued).
- Write stalling: wr_valid_i low stalls LOAD indefinitely; this is not a timeout condition.
- Timeout: a cycle counter is cleared on entering POLL_BUSY and runs through POLL_FREE. Reaching TIMEOUT_CYC aborts the poll: go to STOP, then DONE with err_o=1. A read request skips READ on timeout.
- Reset mid-transfer: the asynchronous reset returns to IDLE immediately. An active APB access is dropped (psel=0).
- Byte counter: 8 bits, never wraps, because len ≤ MAX_LEN.

Optional Feature:
- Macro: I2C_SEQ_TIMEOUT_EN.
- Defined: timeout counter and err_o behave as above.
- Undefined: no counter is built, polling waits forever, and err_o is tied to 0.

Test Plan:
- Write, addr 0x50, len 2, bytes 0xA5/0x3C, pready always 1:
  - APB writes in order: 0x01←0x00, 0x00←0x04, 0x04←0xA0, 0x02←0xA5, 0x02←0x3C, 0x01←0x60.
  - Polls until status 0x00 followed by 0xA0, then 0x01←0x20.
  - done_o pulses once; err_o stays 0.
- Read, addr 0x50, len 3; receive returns 0x11/0x22/0x33; rd_ready low for 5 cycles on byte 2:
  - rd_data_o gives 0x11, 0x22, 0x33 in order.
  - No APB access occurs while stalled.
  - address_rw is written 0xA1.
- pready_i held 0 for 4 cycles on every access → each ACCESS phase lasts 5 cycles; addr/wdata stable throughout.
- Status stuck at 0x20 (bus never busy), TIMEOUT_CYC=100 → abort after 100 cycles; 0x01←0x20 issued; done_o and err_o pulse together.
- req_len=40 with MAX_LEN=16 → exactly 16 transmit writes; req_len=0 → exactly 1.
- preset_n_i asserted during LOAD → all outputs 0 asynchronously; a new request after release starts cleanly with the cmd←0x00 write.

Source files
------------

// File: rtl/i2c_apb_sequencer_if.sv
// Request, byte-stream and APB master signals of the I2C APB sequencer.
// Signal directions are named from the sequencer's point of view.
interface i2c_apb_sequencer_if;
    logic        req_valid_i;
    logic        req_ready_o;
    logic        req_rw_i;
    logic [6:0]  req_addr_i;
    logic [7:0]  req_len_i;
    logic        wr_valid_i;
    logic        wr_ready_o;
    logic [7:0]  wr_data_i;
    logic        rd_valid_o;
    logic        rd_ready_i;
    logic [7:0]  rd_data_o;
    logic        done_o;
    logic        err_o;
    logic        psel_o;
    logic        penable_o;
    logic        pwrite_o;
    logic [31:0] paddr_o;
    logic [31:0] pwdata_o;
    logic [31:0] prdata_i;
    logic        pready_i;

    modport master (
        input  req_valid_i, req_rw_i, req_addr_i, req_len_i,
        input  wr_valid_i, wr_data_i, rd_ready_i, prdata_i, pready_i,
        output req_ready_o, wr_ready_o, rd_valid_o, rd_data_o, done_o, err_o,
        output psel_o, penable_o, pwrite_o, paddr_o, pwdata_o
    );

    modport slave (
        output req_valid_i, req_rw_i, req_addr_i, req_len_i,
        output wr_valid_i, wr_data_i, rd_ready_i, prdata_i, pready_i,
        input  req_ready_o, wr_ready_o, rd_valid_o, rd_data_o, done_o, err_o,
        input  psel_o, penable_o, pwrite_o, paddr_o, pwdata_o
    );
endinterface

// File: rtl/i2c_apb_sequencer.sv
// APB master that runs one complete I2C transfer on the I2C core's register port.
// Poll timeout and err_o reporting are built only when I2C_SEQ_TIMEOUT_EN is defined.
//
// state       | meaning
// IDLE        | waiting for a request, req_ready_o high
// RST         | cmd <- 0x00, holds the I2C core in reset
// PRESC       | prescaler <- PRESC_VAL
// ADDR        | address_rw <- {addr, rw}
// LOAD        | one transmit-register write per accepted write byte
// START       | cmd <- 0x60, enable with reset released
// POLL_BUSY   | read status until bus_free = 0
// POLL_FREE   | read status until bus_free = 1 (and TX empty for writes)
// READ        | receive-register read, byte held on rd_* until taken
// STOP        | cmd <- 0x20, disable
// DONE        | done_o pulse
module i2c_apb_sequencer #(
    parameter logic [7:0]  PRESC_VAL    = 8'd4,
    parameter int          MAX_LEN      = 16,
    parameter logic [31:0] STATUS_ADDR  = 32'h03,
    parameter logic [31:0] RECEIVE_ADDR = 32'h05,
    parameter logic [15:0] TIMEOUT_CYC  = 16'd50000
) (
    input logic                 pclk_i,
    input logic                 preset_n_i,
    i2c_apb_sequencer_if.master bus
);
    typedef enum logic [3:0] {
        S_IDLE, S_RST, S_PRESC, S_ADDR, S_LOAD, S_START,
        S_POLL_BUSY, S_POLL_FREE, S_READ, S_STOP, S_DONE
    } state_t;

    localparam logic [7:0] MAX_LEN_B = 8'(MAX_LEN);

    state_t      state;
    logic        rw_q;
    logic [6:0]  addr_q;
    logic [7:0]  len_q;
    logic [7:0]  cnt_q;
    logic        tmo_flag_q;
    logic        err_q;
    logic        tmo_hit;
    logic [7:0]  len_eff;
    logic [31:0] acc_addr;
    logic [31:0] acc_wdata;
    logic        acc_write;
    logic        acc_start;
    logic        acc_done;
    logic        unused_prdata;

    assign unused_prdata = ^bus.prdata_i[31:8];
    assign acc_done      = bus.psel_o & bus.penable_o & bus.pready_i;
    assign bus.err_o     = err_q;

    always_comb begin
        len_eff = bus.req_len_i;
        if (bus.req_len_i == 8'd0)
            len_eff = 8'd1;
        else if (bus.req_len_i > MAX_LEN_B)
            len_eff = MAX_LEN_B;
    end

    // Register access wanted by the current state; launched only while psel is low.
    always_comb begin
        acc_addr  = 32'h0;
        acc_wdata = 32'h0;
        acc_write = 1'b1;
        acc_start = 1'b0;
        case (state)
            S_RST:       begin acc_addr = 32'h01; acc_start = 1'b1; end
            S_PRESC:     begin acc_addr = 32'h00; acc_wdata = {24'h0, PRESC_VAL}; acc_start = 1'b1; end
            S_ADDR:      begin acc_addr = 32'h04; acc_wdata = {24'h0, addr_q, rw_q}; acc_start = 1'b1; end
            S_LOAD:      begin
                acc_addr  = 32'h02;
                acc_wdata = {24'h0, bus.wr_data_i};
                acc_start = bus.wr_ready_o & bus.wr_valid_i;
            end
            S_START:     begin acc_addr = 32'h01; acc_wdata = 32'h60; acc_start = 1'b1; end
            S_POLL_BUSY,
            S_POLL_FREE: begin acc_addr = STATUS_ADDR; acc_write = 1'b0; acc_start = ~tmo_hit; end
            S_READ:      begin acc_addr = RECEIVE_ADDR; acc_write = 1'b0; acc_start = ~bus.rd_valid_o; end
            S_STOP:      begin acc_addr = 32'h01; acc_wdata = 32'h20; acc_start = 1'b1; end
            default:     ;
        endcase
    end

`ifdef I2C_SEQ_TIMEOUT_EN
    logic [15:0] tmo_cnt;

    always_ff @(posedge pclk_i or negedge preset_n_i) begin
        if (!preset_n_i)
            tmo_cnt <= '0;
        else if (state != S_POLL_BUSY && state != S_POLL_FREE)
            tmo_cnt <= '0;
        else if (!tmo_hit)
            tmo_cnt <= tmo_cnt + 16'd1;
    end

    assign tmo_hit = (tmo_cnt >= TIMEOUT_CYC);
`else
    localparam logic [15:0] unused_timeout_cyc = TIMEOUT_CYC;
    assign tmo_hit = 1'b0;
`endif

    always_ff @(posedge pclk_i or negedge preset_n_i) begin
        if (!preset_n_i) begin
            state           <= S_IDLE;
            rw_q            <= 1'b0;
            addr_q          <= '0;
            len_q           <= '0;
            cnt_q           <= '0;
            tmo_flag_q      <= 1'b0;
            err_q           <= 1'b0;
            bus.req_ready_o <= 1'b0;
            bus.wr_ready_o  <= 1'b0;
            bus.rd_valid_o  <= 1'b0;
            bus.rd_data_o   <= '0;
            bus.done_o      <= 1'b0;
            bus.psel_o      <= 1'b0;
            bus.penable_o   <= 1'b0;
            bus.pwrite_o    <= 1'b0;
            bus.paddr_o     <= '0;
            bus.pwdata_o    <= '0;
        end else begin
            bus.done_o <= 1'b0;
            err_q      <= 1'b0;

            // APB engine: SETUP, ACCESS until pready, then at least one idle cycle.
            if (bus.psel_o) begin
                if (!bus.penable_o) begin
                    bus.penable_o <= 1'b1;
                end else if (bus.pready_i) begin
                    bus.psel_o    <= 1'b0;
                    bus.penable_o <= 1'b0;
                end
            end else if (acc_start) begin
                bus.psel_o   <= 1'b1;
                bus.paddr_o  <= acc_addr;
                bus.pwdata_o <= acc_wdata;
                bus.pwrite_o <= acc_write;
            end

            case (state)
                S_IDLE: begin
                    bus.req_ready_o <= 1'b1;
                    if (bus.req_ready_o && bus.req_valid_i) begin
                        bus.req_ready_o <= 1'b0;
                        rw_q            <= bus.req_rw_i;
                        addr_q          <= bus.req_addr_i;
                        len_q           <= len_eff;
                        cnt_q           <= '0;
                        tmo_flag_q      <= 1'b0;
                        state           <= S_RST;
                    end
                end
                S_RST:   if (acc_done) state <= S_PRESC;
                S_PRESC: if (acc_done) state <= S_ADDR;
                S_ADDR:  if (acc_done) state <= rw_q ? S_START : S_LOAD;
                S_LOAD: begin
                    if (acc_done) begin
                        cnt_q <= cnt_q + 8'd1;
                        if (cnt_q + 8'd1 == len_q)
                            state <= S_START;
                    end else if (!bus.psel_o) begin
                        bus.wr_ready_o <= ~(bus.wr_ready_o & bus.wr_valid_i);
                    end
                end
                S_START: if (acc_done) state <= S_POLL_BUSY;
                S_POLL_BUSY: begin
                    if (acc_done && !bus.prdata_i[5]) begin
                        state <= S_POLL_FREE;
                    end else if (!bus.psel_o && tmo_hit) begin
                        tmo_flag_q <= 1'b1;
                        state      <= S_STOP;
                    end
                end
                S_POLL_FREE: begin
                    if (acc_done && bus.prdata_i[5] && (rw_q || bus.prdata_i[7])) begin
                        state <= rw_q ? S_READ : S_STOP;
                    end else if (!bus.psel_o && tmo_hit) begin
                        tmo_flag_q <= 1'b1;
                        state      <= S_STOP;
                    end
                end
                S_READ: begin
                    if (acc_done) begin
                        bus.rd_data_o  <= bus.prdata_i[7:0];
                        bus.rd_valid_o <= 1'b1;
                    end else if (bus.rd_valid_o && bus.rd_ready_i) begin
                        bus.rd_valid_o <= 1'b0;
                        cnt_q          <= cnt_q + 8'd1;
                        if (cnt_q + 8'd1 == len_q)
                            state <= S_STOP;
                    end
                end
                S_STOP: begin
                    if (acc_done) begin
                        bus.done_o <= 1'b1;
                        err_q      <= tmo_flag_q;
                        state      <= S_DONE;
                    end
                end
                S_DONE:  state <= S_IDLE;
                default: state <= S_IDLE;
            endcase
        end
    end
endmodule
